// File: rtl/rf_seq_pkg.sv
// Shared types and defaults for the register-file sequencer: FSM states,
// instruction opcodes and the default data/address widths.
package rf_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int FN_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_ALU = 2'b00,
    OP_LDI = 2'b01,
    OP_MOV = 2'b10,
    OP_NOP = 2'b11
  } op_e;

endpackage

// File: rtl/rf_sequencer.sv
// Multi-cycle instruction sequencer driving an external register file and
// combinational ALU: IDLE -> (READ -> (EXEC)) -> WB -> IDLE, one instruction at a time.
module rf_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [FN_W-1:0]   instr_fn,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] RA1,
  output logic [ADDR_W-1:0] RA2,
  input  logic [DATA_W-1:0] data_out1,
  input  logic [DATA_W-1:0] data_out2,
  output logic [ADDR_W-1:0] WA,
  output logic [DATA_W-1:0] data_in,
  output logic              write_enable,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FN_W-1:0]   alu_fn,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done
);

  state_e              r_state;
  state_e              w_state_next;
  op_e                 r_op;
  logic [FN_W-1:0]     r_fn;
  logic [ADDR_W-1:0]   r_rd;
  logic [ADDR_W-1:0]   r_rs1;
  logic [ADDR_W-1:0]   r_rs2;
  logic [DATA_W-1:0]   r_opa;
  logic [DATA_W-1:0]   r_opb;
  logic [DATA_W-1:0]   r_result;
  logic                w_accept;
  op_e                 w_in_op;

  assign w_in_op  = op_e'(instr_op);
  assign w_accept = instr_valid && (r_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    instr_ready  = 1'b0;
    done         = 1'b0;
    write_enable = 1'b0;
    case (r_state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (w_accept) begin
          if (w_in_op == OP_ALU || w_in_op == OP_MOV) begin
            w_state_next = ST_READ;
          end else begin
            w_state_next = ST_WB;
          end
        end
      end
      ST_READ: begin
        w_state_next = (r_op == OP_ALU) ? ST_EXEC : ST_WB;
      end
      ST_EXEC: begin
        w_state_next = ST_WB;
      end
      ST_WB: begin
        done         = 1'b1;
        write_enable = (r_op != OP_NOP);
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Instruction fields are captured only on the accept edge; the operand and
  // result registers then advance with the state, so rd may alias rs1/rs2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_ALU;
      r_fn     <= '0;
      r_rd     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op  <= w_in_op;
            r_fn  <= instr_fn;
            r_rd  <= instr_rd;
            r_rs1 <= instr_rs1;
            r_rs2 <= instr_rs2;
            if (w_in_op == OP_LDI) begin
              r_result <= instr_imm;
            end
          end
        end
        ST_READ: begin
          r_opa <= data_out1;
          r_opb <= data_out2;
          if (r_op == OP_MOV) begin
            r_result <= data_out1;
          end
        end
        ST_EXEC: begin
          r_result <= alu_result;
        end
        default: begin
        end
      endcase
    end
  end

  assign RA1     = r_rs1;
  assign RA2     = r_rs2;
  assign WA      = r_rd;
  assign data_in = r_result;
  assign alu_a   = r_opa;
  assign alu_b   = r_opb;
  assign alu_fn  = r_fn;

endmodule

// File: tb/tb_rf_sequencer.sv
// Scoreboard bench: a behavioural register-file model predicts each retirement
// (cycle, write strobe, address, data); a negedge monitor pops and compares.
module tb_rf_sequencer;
  import rf_seq_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    instr_op;
  logic [2:0]    instr_fn;
  logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic [DW-1:0] instr_imm;
  logic [AW-1:0] RA1, RA2, WA;
  logic [DW-1:0] data_out1, data_out2, data_in;
  logic          write_enable;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [2:0]    alu_fn;
  logic          done;

  logic [DW-1:0] rf [16];
  logic [DW-1:0] model_rf [16];
  logic          tb_wr_en;
  logic [AW-1:0] tb_wr_addr;
  logic [DW-1:0] tb_wr_data;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] alu_ref(input logic [2:0] fn, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (fn)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return {a[DW-2:0], a[DW-1]};
      3'd6: return b;
      default: return ~a;
    endcase
  endfunction

  // Environment: register file with combinational reads, and the ALU.
  always @(posedge clk) begin
    if (tb_wr_en) rf[tb_wr_addr] <= tb_wr_data;
    else if (write_enable) rf[WA] <= data_in;
  end
  assign data_out1  = rf[RA1];
  assign data_out2  = rf[RA2];
  assign alu_result = alu_ref(alu_fn, alu_a, alu_b);

  rf_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_fn(instr_fn),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_imm(instr_imm),
    .RA1(RA1), .RA2(RA2), .data_out1(data_out1), .data_out2(data_out2),
    .WA(WA), .data_in(data_in), .write_enable(write_enable),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_result(alu_result),
    .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every retirement must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!reset) begin
      chk("we_outside_wb", 32'(write_enable & ~done), 32'd0);
      if (done) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_retire: got done=1 expected no retirement (cycle %0d)", cyc);
        end else begin
          mon_e = q.pop_front();
          $display("retire cyc=%0d we=%0b WA=%0d data_in=0x%02h", cyc, write_enable, WA, data_in);
          chk("retire_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("write_enable", 32'(write_enable), 32'(mon_e.we));
          if (mon_e.we) begin
            chk("WA", 32'(WA), 32'(mon_e.wa));
            chk("data_in", 32'(data_in), 32'(mon_e.data));
          end
        end
      end
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    tb_wr_en = 1'b1; tb_wr_addr = a; tb_wr_data = d;
    @(negedge clk);
    tb_wr_en = 1'b0;
    model_rf[a] = d;
  endtask

  task automatic randomize_fields();
    instr_op  = 2'($urandom);
    instr_fn  = 3'($urandom);
    instr_rd  = 4'($urandom);
    instr_rs1 = 4'($urandom);
    instr_rs2 = 4'($urandom);
    instr_imm = 8'($urandom);
  endtask

  task automatic idle_gap(input int n);
    @(negedge clk);
    instr_valid = 1'b0;
    randomize_fields();
    repeat (n) begin
      @(negedge clk);
      randomize_fields();
    end
  endtask

  // Offers an instruction, waits (bounded) for acceptance, returns the accept
  // edge index and predicts the retirement from the reference register file.
  task automatic issue(input logic [1:0] op, input logic [2:0] fn, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [DW-1:0] imm, input bit expect_it, output int t);
    exp_t e;
    int   k;
    int   lat;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = op; instr_fn = fn; instr_rd = rd;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    k = 0;
    while (!instr_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept_within_budget", 32'(instr_ready), 32'd1);
    if (!instr_ready) begin
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "sequencer never became ready");
    end
    @(posedge clk);
    #1;
    t = cyc;
    $display("issue cyc=%0d op=%0d fn=%0d rd=%0d rs1=%0d rs2=%0d imm=0x%02h", t, op, fn, rd, rs1, rs2, imm);
    if (expect_it) begin
      e.wa = rd;
      e.we = 1'b1;
      case (op)
        2'b00: begin e.data = alu_ref(fn, model_rf[rs1], model_rf[rs2]); lat = 3; end
        2'b01: begin e.data = imm; lat = 1; end
        2'b10: begin e.data = model_rf[rs1]; lat = 2; end
        default: begin e.data = '0; e.we = 1'b0; lat = 1; end
      endcase
      // Visible in the WB cycle, whose closing edge (T+lat) performs the write.
      e.cyc = t + lat - 1;
      if (e.we) model_rf[rd] = e.data;
      q.push_back(e);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_instr_ready"}, 32'(instr_ready), 32'd1);
    chk({tag, "_write_enable"}, 32'(write_enable), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_RA1"}, 32'(RA1), 32'd0);
    chk({tag, "_RA2"}, 32'(RA2), 32'd0);
    chk({tag, "_WA"}, 32'(WA), 32'd0);
    chk({tag, "_data_in"}, 32'(data_in), 32'd0);
    chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    chk({tag, "_alu_fn"}, 32'(alu_fn), 32'd0);
  endtask

  initial begin
    int t, t1, t2, t3, k;
    reset = 1'b1;
    instr_valid = 1'b0;
    tb_wr_en = 1'b0; tb_wr_addr = '0; tb_wr_data = '0;
    randomize_fields();
    for (int i = 0; i < 16; i++) poke(4'(i), 8'($urandom));
    poke(4'd1, 8'h10);
    poke(4'd2, 8'h22);
    @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    // LDI rd=3 imm=0x5A
    issue(2'b01, 3'd0, 4'd3, 4'd0, 4'd0, 8'h5A, 1'b1, t);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("ldi_ready_in_wb", 32'(instr_ready), 32'd0);
    @(negedge clk);
    chk("ldi_ready_after_wb", 32'(instr_ready), 32'd1);

    // ALU add rd=4 rs1=1 rs2=2
    issue(2'b00, 3'd0, 4'd4, 4'd1, 4'd2, 8'h00, 1'b1, t);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("alu_RA1", 32'(RA1), 32'd1);
    chk("alu_RA2", 32'(RA2), 32'd2);
    @(negedge clk);
    chk("alu_a", 32'(alu_a), 32'h10);
    chk("alu_b", 32'(alu_b), 32'h22);
    chk("alu_fn", 32'(alu_fn), 32'd0);
    @(negedge clk);
    chk("alu_data_in_0x32", 32'(data_in), 32'h32);

    // MOV rd=7 rs1=1, then NOP
    issue(2'b10, 3'd0, 4'd7, 4'd1, 4'd0, 8'h00, 1'b1, t);
    idle_gap(2);
    issue(2'b11, 3'd0, 4'd1, 4'd2, 4'd3, 8'hFF, 1'b1, t);
    idle_gap(1);

    // Three back-to-back ALU ops with valid held high
    issue(2'b00, 3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), 1'b1, t1);
    issue(2'b00, 3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), 1'b1, t2);
    issue(2'b00, 3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), 1'b1, t3);
    chk("b2b_spacing_1", 32'(t2 - t1), 32'd4);
    chk("b2b_spacing_2", 32'(t3 - t2), 32'd4);
    idle_gap(3);

    // Reset during EXEC aborts the op; reset also wins over an offered LDI
    issue(2'b00, 3'd0, 4'd9, 4'd1, 4'd2, 8'h00, 1'b0, t);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_exec_alu_a", 32'(alu_a), 32'h10);
    reset = 1'b1;
    instr_valid = 1'b1; instr_op = 2'b01; instr_rd = 4'd9; instr_imm = 8'hEE;
    @(negedge clk);
    chk_reset_outputs("abort");
    reset = 1'b0;
    instr_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_write", 32'(write_enable), 32'd0);
    end

    // ALU rd=rs1=rs2=5, r5=0x03, add -> 0x06
    poke(4'd5, 8'h03);
    issue(2'b00, 3'd0, 4'd5, 4'd5, 4'd5, 8'h00, 1'b1, t);
    idle_gap(4);
    chk("r5_doubled", 32'(rf[5]), 32'h06);

    // Randomized traffic with random idle gaps and junk fields while busy
    for (int i = 0; i < 150; i++) begin
      issue(2'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            8'($urandom), 1'b1, t);
      if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(0, 2));
      else begin
        @(negedge clk);
        randomize_fields();
      end
    end

    @(negedge clk);
    instr_valid = 1'b0;
    k = 0;
    while ((q.size() != 0 || !instr_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("rf_final_r%0d", i), 32'(rf[i]), 32'(model_rf[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
